step_sequencer: RTL

Multi-axis step-pulse scheduler for the printer's five stepper channels (X, Y, Z, E0, E1). Accepts one linear-move command at a time over a valid/ready handshake and distributes step pulses across axes with Bresenham accumulators at a fixed event period. Its five 3-bit outputs feed the step_motor_* export ports of soc_system. X/Y/Z min/max endstops are honoured per step.

---
 rtl/step_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: five-axis Bresenham step-pulse scheduler with endstop suppression and abort
module step_sequencer #(
    parameter int STEP_W    = 16,
    parameter int PERIOD_W  = 16,
    parameter int PULSE_W   = 50,
    parameter int DIR_SETUP = 25
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [5*STEP_W-1:0]   cmd_steps,
    input  logic [4:0]            cmd_dir,
    input  logic [PERIOD_W-1:0]   cmd_period,
    input  logic [2:0]            endstop_min,
    input  logic [2:0]            endstop_max,
    input  logic                  abort,
    input  logic                  motor_en,
    output logic [2:0]            step_motor_x,
    output logic [2:0]            step_motor_y,
    output logic [2:0]            step_motor_z,
    output logic [2:0]            step_motor_e0,
    output logic [2:0]            step_motor_e1,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [2:0]            endstop_hit
);
    typedef enum logic [1:0] {IDLE, LOAD, SETUP, RUN} state_t;

    localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_W - 1);
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(2 * PULSE_W);
    localparam logic [15:0]         SETUP_LAST = 16'(DIR_SETUP - 1);

    state_t state, state_nx;
    logic [STEP_W-1:0]   steps [5];
    logic [STEP_W:0]     acc [5];
    logic [STEP_W:0]     sum [5];
    logic [STEP_W:0]     acc_nx [5];
    logic [4:0]          dir_cmd, dir, step, req, sup;
    logic [PERIOD_W-1:0] period, p_last, pcnt;
    logic [STEP_W-1:0]   n, n_max, ev_left;
    logic [15:0]         scnt;
    logic [2:0]          min_s1, min_s, max_s1, max_s;
    logic                abort_q, abort_any, fire, fin, fin_ab, en;

    assign busy      = state != IDLE;
    assign cmd_ready = (state == IDLE) && reset_reset_n;
    assign en        = (busy | motor_en) & reset_reset_n;
    assign abort_any = abort | abort_q;
    assign p_last    = (period > MIN_P ? period : MIN_P) - PERIOD_W'(1);

    assign step_motor_x  = {en, dir[0], step[0]};
    assign step_motor_y  = {en, dir[1], step[1]};
    assign step_motor_z  = {en, dir[2], step[2]};
    assign step_motor_e0 = {en, dir[3], step[3]};
    assign step_motor_e1 = {en, dir[4], step[4]};

    // move length is the largest per-axis count
    always_comb begin
        n_max = '0;
        for (int i = 0; i < 5; i++) n_max = steps[i] > n_max ? steps[i] : n_max;
    end

    // Bresenham update for every axis plus endstop suppression on X/Y/Z
    always_comb begin
        req = '0;
        for (int i = 0; i < 5; i++) begin
            sum[i]    = acc[i] + {1'b0, steps[i]};
            req[i]    = sum[i] >= {1'b0, n};
            acc_nx[i] = req[i] ? sum[i] - {1'b0, n} : sum[i];
        end
        sup = {2'b00, req[2:0] & ((min_s & ~dir[2:0]) | (max_s & dir[2:0]))};
    end

    // next-state logic; fire marks the edge that launches an event period
    always_comb begin
        state_nx = state;
        fire     = 1'b0;
        fin      = 1'b0;
        fin_ab   = 1'b0;
        case (state)
            IDLE:  state_nx = cmd_valid ? LOAD : IDLE;
            LOAD: begin
                fin      = abort || n_max == '0;
                fin_ab   = abort;
                state_nx = fin ? IDLE : SETUP;
            end
            SETUP: begin
                fin      = abort;
                fin_ab   = abort;
                fire     = !abort && scnt == SETUP_LAST;
                state_nx = abort ? IDLE : fire ? RUN : SETUP;
            end
            RUN: begin
                fin_ab   = abort_any && pcnt >= PULSE_LAST;
                fin      = fin_ab || (!abort_any && pcnt == p_last && ev_left == '0);
                fire     = !abort_any && pcnt == p_last && ev_left != '0;
                state_nx = fin ? IDLE : RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= state_nx;
    end

    // two-flop synchronizers for the asynchronous endstops
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            min_s1 <= '0;
            min_s  <= '0;
            max_s1 <= '0;
            max_s  <= '0;
        end else begin
            min_s1 <= endstop_min;
            min_s  <= min_s1;
            max_s1 <= endstop_max;
            max_s  <= max_s1;
        end
    end

    // command latch, accumulators, period timing and step/status outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 5; i++) begin
                steps[i] <= '0;
                acc[i]   <= '0;
            end
            dir_cmd     <= '0;
            dir         <= '0;
            step        <= '0;
            period      <= '0;
            pcnt        <= '0;
            n           <= '0;
            ev_left     <= '0;
            scnt        <= '0;
            abort_q     <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            endstop_hit <= '0;
        end else begin
            done    <= fin;
            aborted <= fin_ab;
            abort_q <= state_nx == RUN && abort_any;
            if (state == IDLE && cmd_valid) begin
                for (int i = 0; i < 5; i++) steps[i] <= cmd_steps[i*STEP_W +: STEP_W];
                dir_cmd     <= cmd_dir;
                period      <= cmd_period;
                endstop_hit <= '0;
            end
            if (state == LOAD) begin
                n    <= n_max;
                scnt <= '0;
                for (int i = 0; i < 5; i++) acc[i] <= {1'b0, n_max >> 1};
                if (!fin) dir <= dir_cmd;
            end
            if (state == SETUP) scnt <= scnt + 16'd1;
            if (fire) begin
                for (int i = 0; i < 5; i++) acc[i] <= acc_nx[i];
                step        <= req & ~sup;
                endstop_hit <= endstop_hit | sup[2:0];
                pcnt        <= '0;
                ev_left     <= state == SETUP ? n - STEP_W'(1) : ev_left - STEP_W'(1);
            end else if (state == RUN) begin
                pcnt <= pcnt + PERIOD_W'(1);
                step <= (pcnt == PULSE_LAST || fin) ? '0 : step;
            end
        end
    end
endmodule
